serial_sum_decomposer: RTL and testbench

SERIAL_SUM_DECOMPOSER -- requirements
Module: serial_sum_decomposer

---
 rtl/serial_sum_decomposer.sv | 93 +++++++++
 tb/tb_serial_sum_decomposer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/serial_sum_decomposer.sv
// Bit-serial recovery of operand A from a (WIDTH+1)-bit sum and known operand B.
// One difference bit per cycle, LSB first, with a ripple borrow flop.
module serial_sum_decomposer #(
    parameter int WIDTH = 16
) (
    input  logic             pclk,
    input  logic             prst,
    input  logic             pstart,
    input  logic [WIDTH:0]   psum,
    input  logic [WIDTH-1:0] pb,
    output logic [WIDTH-1:0] pa,
    output logic             perr,
    output logic             pvalid,
    output logic             pbusy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t state, state_nxt;

    logic [WIDTH:0]   sum_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             s_i, b_i, diff, borrow_nxt;

    assign s_i        = sum_sr[0];
    assign b_i        = b_sr[0];
    assign diff       = s_i ^ b_i ^ borrow;
    assign borrow_nxt = (~s_i & b_i) | (~(s_i ^ b_i) & borrow);

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pvalid    = 1'b0;
        pbusy     = 1'b0;
        case (state)
            IDLE:  if (pstart) state_nxt = SHIFT;
            SHIFT: begin
                pbusy = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                pbusy     = 1'b1;
                pvalid    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // b_sr zero-fills from the top, so the B bit seen at index WIDTH is 0.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            sum_sr <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            pa     <= '0;
            perr   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pstart) begin
                    sum_sr <= psum;
                    b_sr   <= pb;
                    borrow <= 1'b0;
                    cnt    <= '0;
                end
                SHIFT: begin
                    sum_sr <= sum_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    borrow <= borrow_nxt;
                    cnt    <= cnt + 1'b1;
                    if (cnt != LAST) begin
                        res_sr <= {diff, res_sr[WIDTH-1:1]};
                    end else begin
                        pa   <= res_sr;
                        perr <= diff | borrow_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sum_decomposer.sv
// Bench for serial_sum_decomposer: directed corner cases, back-to-back, mid-op reset,
// and randomized vectors on WIDTH=16 and WIDTH=4 instances against an arithmetic model.
module tb_serial_sum_decomposer;
    logic pclk = 1'b0;
    logic prst;
    always #5 pclk = ~pclk;

    logic [16:0] s16; logic [15:0] b16, a16; logic st16, e16, v16, y16;
    logic [4:0]  s4;  logic [3:0]  b4,  a4;  logic st4,  e4,  v4,  y4;

    serial_sum_decomposer #(.WIDTH(16)) dut16 (
        .pclk(pclk), .prst(prst), .pstart(st16), .psum(s16), .pb(b16),
        .pa(a16), .perr(e16), .pvalid(v16), .pbusy(y16));

    serial_sum_decomposer #(.WIDTH(4)) dut4 (
        .pclk(pclk), .prst(prst), .pstart(st4), .psum(s4), .pb(b4),
        .pa(a4), .perr(e4), .pvalid(v4), .pbusy(y4));

    int vectors = 0;
    int miscompares = 0;
    bit sel4 = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_v();    return sel4 ? v4 : v16;                 endfunction
    function automatic logic cur_y();    return sel4 ? y4 : y16;                 endfunction
    function automatic logic cur_e();    return sel4 ? e4 : e16;                 endfunction
    function automatic logic [15:0] cur_a(); return sel4 ? {12'h0, a4} : a16;    endfunction

    task automatic set_in(input logic [32:0] s, input logic [31:0] b, input logic st);
        if (sel4) begin s4 = s[4:0];  b4 = b[3:0];   st4 = st; end
        else      begin s16 = s[16:0]; b16 = b[15:0]; st16 = st; end
    endtask

    // Model: plain signed subtraction of the operands, reduced/range-checked against 2^w.
    task automatic run_op(input string tag, input logic [32:0] s, input logic [31:0] b);
        int w;
        longint sm, bm, d;
        logic [63:0] epa;
        logic eerr;
        int lat;
        w    = sel4 ? 4 : 16;
        sm   = longint'(s) & ((longint'(1) << (w + 1)) - 1);
        bm   = longint'(b) & ((longint'(1) << w) - 1);
        d    = sm - bm;
        epa  = 64'(d & ((longint'(1) << w) - 1));
        eerr = (d < 0) || (d >= (longint'(1) << w));
        @(negedge pclk);
        set_in(33'(sm), 32'(bm), 1'b1);
        @(posedge pclk); #1;
        set_in(~33'(sm), ~32'(bm), 1'b0);
        lat = 1;
        while (!cur_v() && lat < 3 * w + 10) begin
            @(posedge pclk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(w + 2));
        check({tag, " pa"}, 64'(cur_a()), epa);
        check({tag, " perr"}, 64'(cur_e()), 64'(eerr));
        @(posedge pclk); #1;
        check({tag, " pvalid one cycle"}, 64'(cur_v()), 64'd0);
        check({tag, " idle after done"}, 64'(cur_y()), 64'd0);
    endtask

    initial begin
        int since, idle_cnt, nvalid, cyc, nv;
        prst = 1'b1;
        s16 = '0; b16 = '0; st16 = 1'b0;
        s4  = '0; b4  = '0; st4  = 1'b0;
        #12;
        check("rst pa16", 64'(a16), 64'd0);   check("rst perr16", 64'(e16), 64'd0);
        check("rst pvalid16", 64'(v16), 64'd0); check("rst pbusy16", 64'(y16), 64'd0);
        check("rst pa4", 64'(a4), 64'd0);     check("rst perr4", 64'(e4), 64'd0);
        check("rst pvalid4", 64'(v4), 64'd0); check("rst pbusy4", 64'(y4), 64'd0);
        @(negedge pclk); prst = 1'b0;

        sel4 = 1'b0;
        run_op("dir 1234-34", 33'h01234, 32'h0034);
        run_op("dir 1fffe-ffff", 33'h1FFFE, 32'hFFFF);
        run_op("dir 10000-0", 33'h10000, 32'h0000);
        run_op("dir 5-6", 33'h00005, 32'h0006);

        // pstart held high: fixed 19-cycle cadence, inputs scrambled while in flight
        since = -1; idle_cnt = 0; nvalid = 0; cyc = 0;
        @(negedge pclk); set_in(33'h01234, 32'h34, 1'b1);
        while (nvalid < 4 && cyc < 200) begin
            @(posedge pclk); #1;
            cyc++;
            if (since >= 0) since++;
            if (!y16) idle_cnt++;
            if (v16) begin
                check("b2b pa", 64'(a16), 64'h1200);
                check("b2b perr", 64'(e16), 64'd0);
                if (nvalid > 0) begin
                    check("b2b interval", 64'(since), 64'd19);
                    check("b2b idle cycles", 64'(idle_cnt), 64'd1);
                end
                nvalid++; since = 0; idle_cnt = 0;
                set_in(33'h01234, 32'h34, 1'b1);
            end else if (since == 2) begin
                set_in(33'h1FFFF, 32'h0, 1'b1);
            end
        end
        set_in(33'h0, 32'h0, 1'b0);
        check("b2b completions", 64'(nvalid), 64'd4);
        repeat (25) @(posedge pclk);

        // asynchronous reset in the middle of SHIFT
        @(negedge pclk); set_in(33'h01234, 32'h34, 1'b1);
        @(posedge pclk); #1; set_in(33'h01234, 32'h34, 1'b0);
        repeat (8) @(posedge pclk);
        #2 prst = 1'b1;
        #1;
        check("midrst pa", 64'(a16), 64'd0);     check("midrst perr", 64'(e16), 64'd0);
        check("midrst pvalid", 64'(v16), 64'd0); check("midrst pbusy", 64'(y16), 64'd0);
        @(negedge pclk); prst = 1'b0;
        nv = 0;
        repeat (30) begin @(posedge pclk); #1; if (v16) nv++; end
        check("midrst no pvalid", 64'(nv), 64'd0);
        run_op("post-rst 1234-34", 33'h01234, 32'h0034);

        for (int i = 0; i < 1500; i++) begin
            logic [32:0] rs; logic [31:0] rb;
            rs = 33'($urandom_range(0, 32'h1FFFF));
            rb = (i % 4 == 0) ? 32'(rs[15:0] ^ 32'($urandom_range(0, 3))) : 32'($urandom_range(0, 32'hFFFF));
            run_op("rand16", rs, rb);
        end

        sel4 = 1'b1;
        run_op("w4 10-0", 33'h10, 32'h0);
        run_op("w4 1e-f", 33'h1E, 32'hF);
        for (int i = 0; i < 2000; i++) begin
            run_op("rand4", 33'($urandom_range(0, 31)), 32'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
